// File: rtl/reg_file_sb.sv
// Multi-port integer register file: two write ports (B wins on conflict), NREAD
// combinational read ports with optional write bypass, and a per-register busy scoreboard.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    input  logic [AW-1:0]         wa_a,
    input  logic [AW-1:0]         wa_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [XLEN-1:0]       wd_a,
    input  logic [XLEN-1:0]       wd_b,
    input  logic                  clr_a,
    input  logic                  clr_b,
    input  logic                  iss_v,
    input  logic [AW-1:0]         iss_addr
);

    logic             wr_a;
    logic             wr_b;
    logic [XLEN-1:0]  reg_view [NREGS];
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    assign wr_a = we_a && (wa_a != '0);
    assign wr_b = we_b && (wa_b != '0);

    // One storage register per architectural register; x0 is a constant zero.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_view[gi] = '0;
            end else begin : g_store
                localparam logic [AW-1:0] IDX = AW'(gi);
                logic [XLEN-1:0] data_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        data_reg <= '0;
                    end else if (wr_b && (wa_b == IDX)) begin
                        data_reg <= wd_b;
                    end else if (wr_a && (wa_a == IDX)) begin
                        data_reg <= wd_a;
                    end
                end

                assign reg_view[gi] = data_reg;
            end
        end
    endgenerate

    // Clears are applied before the set so a retiring and a newly issued producer
    // on the same register leave it busy.
    always_comb begin
        busy_next = busy_reg;
        if (wr_a && clr_a) begin
            busy_next[wa_a] = 1'b0;
        end
        if (wr_b && clr_b) begin
            busy_next[wa_b] = 1'b0;
        end
        if (iss_v) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;

            assign addr = ra[gi*AW +: AW];

            always_comb begin
                data = reg_view[addr];
                if (BYPASS != 0) begin
                    if (wr_a && (wa_a == addr)) begin
                        data = wd_a;
                    end
                    if (wr_b && (wa_b == addr)) begin
                        data = wd_b;
                    end
                end
                if (rst || (addr == '0)) begin
                    data = '0;
                end
            end

            assign rd[gi*XLEN +: XLEN] = data;
            assign rbusy[gi] = !rst && (addr != '0) && busy_reg[addr];
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: two instances (32x32b/2 ports/bypass and 16x64b/3 ports/no bypass)
// share one stimulus stream; expectations come from a plain array model of the register file.
module tb_reg_file_sb;

    logic         clk = 1'b0;
    logic         rst;
    logic         we_a, we_b, clr_a, clr_b, iss_v;

    logic [9:0]   ra0;
    logic [63:0]  rd0;
    logic [1:0]   rbusy0;
    logic [4:0]   wa0_a, wa0_b, iss0;
    logic [31:0]  wd0_a, wd0_b;

    logic [11:0]  ra1;
    logic [191:0] rd1;
    logic [2:0]   rbusy1;
    logic [3:0]   wa1_a, wa1_b, iss1;
    logic [63:0]  wd1_a, wd1_b;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst), .ra(ra0), .rd(rd0), .rbusy(rbusy0),
        .wa_a(wa0_a), .wa_b(wa0_b), .we_a(we_a), .we_b(we_b),
        .wd_a(wd0_a), .wd_b(wd0_b), .clr_a(clr_a), .clr_b(clr_b),
        .iss_v(iss_v), .iss_addr(iss0)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst), .ra(ra1), .rd(rd1), .rbusy(rbusy1),
        .wa_a(wa1_a), .wa_b(wa1_b), .we_a(we_a), .we_b(we_b),
        .wd_a(wd1_a), .wd_b(wd1_b), .clr_a(clr_a), .clr_b(clr_b),
        .iss_v(iss_v), .iss_addr(iss1)
    );

    typedef struct {
        int           id;
        logic [63:0]  rd0;
        logic [1:0]   rb0;
        logic [191:0] rd1;
        logic [2:0]   rb1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    // Reference model: architectural contents and busy flags of both instances.
    logic [31:0] m0 [32];
    logic        b0 [32];
    logic [63:0] m1 [16];
    logic        b1 [16];

    // Stimulus for the coming cycle
    logic        s_rst, s_we_a, s_we_b, s_clr_a, s_clr_b, s_iss_v;
    logic [4:0]  s_wa_a, s_wa_b, s_iss;
    logic [63:0] s_wd_a, s_wd_b;
    logic [4:0]  s_ra [3];

    task automatic idle();
        s_rst = 1'b0; s_we_a = 1'b0; s_we_b = 1'b0; s_clr_a = 1'b0; s_clr_b = 1'b0;
        s_iss_v = 1'b0; s_wa_a = '0; s_wa_b = '0; s_iss = '0; s_wd_a = '0; s_wd_b = '0;
        for (int p = 0; p < 3; p++) s_ra[p] = '0;
    endtask

    task automatic read_all(input logic [4:0] a);
        for (int p = 0; p < 3; p++) s_ra[p] = a;
    endtask

    task automatic step();
        exp_t        e;
        logic [4:0]  a5;
        logic [3:0]  a4;
        logic [31:0] v32;
        logic [63:0] v64;
        @(posedge clk);
        #1;
        rst = s_rst; we_a = s_we_a; we_b = s_we_b; clr_a = s_clr_a; clr_b = s_clr_b;
        iss_v = s_iss_v;
        wa0_a = s_wa_a; wa0_b = s_wa_b; iss0 = s_iss;
        wd0_a = s_wd_a[31:0]; wd0_b = s_wd_b[31:0];
        wa1_a = s_wa_a[3:0]; wa1_b = s_wa_b[3:0]; iss1 = s_iss[3:0];
        wd1_a = s_wd_a; wd1_b = s_wd_b;
        ra0 = {s_ra[1], s_ra[0]};
        ra1 = {s_ra[2][3:0], s_ra[1][3:0], s_ra[0][3:0]};

        e.id = txn;
        e.rd0 = '0; e.rb0 = '0; e.rd1 = '0; e.rb1 = '0;
        // Instance 0: same-cycle writes are visible, port B taking precedence.
        for (int p = 0; p < 2; p++) begin
            a5 = s_ra[p];
            if (!s_rst && a5 != 0) begin
                v32 = m0[a5];
                if (s_we_a && s_wa_a == a5) v32 = s_wd_a[31:0];
                if (s_we_b && s_wa_b == a5) v32 = s_wd_b[31:0];
                e.rd0[p*32 +: 32] = v32;
                e.rb0[p] = b0[a5];
            end
        end
        // Instance 1: reads always return the stored value.
        for (int p = 0; p < 3; p++) begin
            a4 = s_ra[p][3:0];
            if (!s_rst && a4 != 0) begin
                v64 = m1[a4];
                e.rd1[p*64 +: 64] = v64;
                e.rb1[p] = b1[a4];
            end
        end
        q.push_back(e);
        txn++;

        if (s_rst) begin
            for (int i = 0; i < 32; i++) begin m0[i] = '0; b0[i] = 1'b0; end
            for (int i = 0; i < 16; i++) begin m1[i] = '0; b1[i] = 1'b0; end
        end else begin
            if (s_we_a && s_wa_a != 0) m0[s_wa_a] = s_wd_a[31:0];
            if (s_we_b && s_wa_b != 0) m0[s_wa_b] = s_wd_b[31:0];
            if (s_we_a && s_clr_a && s_wa_a != 0) b0[s_wa_a] = 1'b0;
            if (s_we_b && s_clr_b && s_wa_b != 0) b0[s_wa_b] = 1'b0;
            if (s_iss_v && s_iss != 0) b0[s_iss] = 1'b1;

            if (s_we_a && s_wa_a[3:0] != 0) m1[s_wa_a[3:0]] = s_wd_a;
            if (s_we_b && s_wa_b[3:0] != 0) m1[s_wa_b[3:0]] = s_wd_b;
            if (s_we_a && s_clr_a && s_wa_a[3:0] != 0) b1[s_wa_a[3:0]] = 1'b0;
            if (s_we_b && s_clr_b && s_wa_b[3:0] != 0) b1[s_wa_b[3:0]] = 1'b0;
            if (s_iss_v && s_iss[3:0] != 0) b1[s_iss[3:0]] = 1'b1;
        end
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    // Monitor: outputs are stable in the second half of every cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 4;
            if (rd0 !== e.rd0) begin
                errors++;
                $display("FAIL rd0 txn %0d: got %h expected %h", e.id, rd0, e.rd0);
            end
            if (rbusy0 !== e.rb0) begin
                errors++;
                $display("FAIL rbusy0 txn %0d: got %b expected %b", e.id, rbusy0, e.rb0);
            end
            if (rd1 !== e.rd1) begin
                errors++;
                $display("FAIL rd1 txn %0d: got %h expected %h", e.id, rd1, e.rd1);
            end
            if (rbusy1 !== e.rb1) begin
                errors++;
                $display("FAIL rbusy1 txn %0d: got %b expected %b", e.id, rbusy1, e.rb1);
            end
            $display("txn %0d rst=%b ra0=%h rd0=%h rbusy0=%b ra1=%h rbusy1=%b",
                     e.id, rst, ra0, rd0, rbusy0, ra1, rbusy1);
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin m0[i] = '0; b0[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin m1[i] = '0; b1[i] = 1'b0; end
        rst = 1'b1; we_a = 1'b0; we_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0; iss_v = 1'b0;
        ra0 = '0; ra1 = '0; wa0_a = '0; wa0_b = '0; iss0 = '0; wd0_a = '0; wd0_b = '0;
        wa1_a = '0; wa1_b = '0; iss1 = '0; wd1_a = '0; wd1_b = '0;

        // Reset, with a write to x5 that must be discarded
        idle(); s_rst = 1'b1; s_we_a = 1'b1; s_wa_a = 5'd5; s_wd_a = 64'h1; read_all(5'd5);
        step(); step();
        idle(); read_all(5'd5); step();

        // Write then reset clears x5
        idle(); s_we_a = 1'b1; s_wa_a = 5'd5; s_wd_a = 64'hDEADBEEF; s_iss_v = 1'b1; s_iss = 5'd5;
        read_all(5'd5); step();
        idle(); read_all(5'd5); step();
        idle(); s_rst = 1'b1; read_all(5'd5); step();
        idle(); read_all(5'd5); step();

        // x0 immunity
        idle(); s_we_a = 1'b1; s_wa_a = 5'd0; s_wd_a = '1; s_iss_v = 1'b1; s_iss = 5'd0;
        read_all(5'd0); step();
        idle(); read_all(5'd0); step();

        // Dual write to x7, B wins
        idle(); s_we_a = 1'b1; s_we_b = 1'b1; s_wa_a = 5'd7; s_wa_b = 5'd7;
        s_wd_a = 64'h11; s_wd_b = 64'h22; read_all(5'd7); step();
        idle(); read_all(5'd7); step();

        // Issue x3, retire it four cycles later
        idle(); s_iss_v = 1'b1; s_iss = 5'd3; read_all(5'd3); step();
        for (int c = 0; c < 3; c++) begin idle(); read_all(5'd3); step(); end
        idle(); s_we_a = 1'b1; s_clr_a = 1'b1; s_wa_a = 5'd3; s_wd_a = 64'h5A; read_all(5'd3); step();
        idle(); read_all(5'd3); step();

        // Issue and retire on x9 in the same cycle: stays busy
        idle(); s_we_b = 1'b1; s_clr_b = 1'b1; s_wa_b = 5'd9; s_wd_b = 64'h99;
        s_iss_v = 1'b1; s_iss = 5'd9; read_all(5'd9); step();
        idle(); read_all(5'd9); step(); step();

        // clr without write enable is ignored
        idle(); s_clr_a = 1'b1; s_wa_a = 5'd9; read_all(5'd9); step();
        idle(); read_all(5'd9); step();

        // 64-bit value on x15, then independent ports
        idle(); s_we_a = 1'b1; s_wa_a = 5'd15; s_wd_a = 64'h0123456789ABCDEF; read_all(5'd15); step();
        idle(); read_all(5'd15); step();
        idle(); s_ra[0] = 5'd15; s_ra[1] = 5'd7; s_ra[2] = 5'd3; step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            s_rst   = ($urandom_range(0, 59) == 0);
            s_we_a  = 1'($urandom_range(0, 1));
            s_we_b  = 1'($urandom_range(0, 1));
            s_clr_a = 1'($urandom_range(0, 1));
            s_clr_b = 1'($urandom_range(0, 1));
            s_iss_v = 1'($urandom_range(0, 1));
            s_wa_a  = rand_addr();
            s_wa_b  = ($urandom_range(0, 3) == 0) ? s_wa_a : rand_addr();
            s_iss   = ($urandom_range(0, 3) == 0) ? s_wa_b : rand_addr();
            s_wd_a  = {$urandom, $urandom};
            s_wd_b  = {$urandom, $urandom};
            for (int p = 0; p < 3; p++) begin
                case ($urandom_range(0, 3))
                    0:       s_ra[p] = s_wa_a;
                    1:       s_ra[p] = s_wa_b;
                    default: s_ra[p] = rand_addr();
                endcase
            end
            step();
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
